// File: rtl/pwm_multi_channel_if.sv
// Button inputs, channel select and PWM outputs of pwm_multi_channel.
// master drives the buttons and ch_sel; slave is the PWM generator.
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 4,
  parameter int RES_BITS = 8
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                inc_n;
  logic                dec_n;
  logic [SEL_W-1:0]    ch_sel;
  logic [CHANNELS-1:0] pwm_out;
  logic [RES_BITS-1:0] duty_view;
  logic                period_start;

  modport master (
    output inc_n, dec_n, ch_sel,
    input  pwm_out, duty_view, period_start
  );

  modport slave (
    input  inc_n, dec_n, ch_sel,
    output pwm_out, duty_view, period_start
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with debounced inc/dec buttons and a shared period counter.
// Define PWM_CENTER_ALIGNED_EN for a triangle counter (needs RES_BITS >= 2); default is sawtooth.
module pwm_multi_channel #(
  parameter int CHANNELS     = 4,
  parameter int RES_BITS     = 8,
  parameter int PRESCALE     = 50,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int DUTY_STEP    = 16,
  parameter int DUTY_INIT    = 0
) (
  input logic               clk,
  input logic               rst,
  pwm_multi_channel_if.slave bus_if
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [RES_BITS-1:0] DMAX    = '1;
  localparam logic [RES_BITS-1:0] CNT_TOP = RES_BITS'((2 ** RES_BITS) - 2);
  localparam logic [RES_BITS-1:0] INIT    = RES_BITS'(DUTY_INIT);
  localparam logic [RES_BITS:0]   STEP    = (RES_BITS + 1)'(DUTY_STEP);
  localparam logic [PS_W-1:0]     PS_TOP  = PS_W'(PRESCALE - 1);
  localparam logic [DB_W-1:0]     DB_TOP  = DB_W'(DEBOUNCE_CYC - 1);

  // bit 0 = increment button, bit 1 = decrement button
  logic [1:0]          raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          level_q, level_d;
  logic [1:0]          ev_q, ev_d;
  logic [DB_W-1:0]     db_cnt_q [2];
  logic [DB_W-1:0]     db_cnt_d [2];

  logic [RES_BITS-1:0] target_q [CHANNELS];
  logic [RES_BITS-1:0] target_d [CHANNELS];
  logic [RES_BITS-1:0] active_q [CHANNELS];

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [RES_BITS-1:0] cnt_q, cnt_d;
  logic                tick, boundary;

  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [RES_BITS-1:0] duty_view_q;
  logic                period_start_q;

  logic                sel_ok;
  logic [RES_BITS-1:0] cur_duty, inc_duty, dec_duty;
  logic [RES_BITS:0]   inc_sum;

  assign raw = {bus_if.dec_n, bus_if.inc_n};

  // A level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    ev_d    = '0;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_TOP) begin
          level_d[b] = sync2_q[b];
          ev_d[b]    = ~sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  generate
    if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = ({1'b0, bus_if.ch_sel} < (SEL_W + 1)'(CHANNELS));
    end
  endgenerate

  assign cur_duty = sel_ok ? target_q[bus_if.ch_sel] : '0;
  assign inc_sum  = {1'b0, cur_duty} + STEP;
  assign inc_duty = (inc_sum > {1'b0, DMAX}) ? DMAX : inc_sum[RES_BITS-1:0];
  assign dec_duty = ({1'b0, cur_duty} < STEP) ? '0 : cur_duty - STEP[RES_BITS-1:0];

  // Simultaneous inc and dec events cancel out.
  always_comb begin
    target_d = target_q;
    if (sel_ok && (ev_q == 2'b01)) begin
      target_d[bus_if.ch_sel] = inc_duty;
    end else if (sel_ok && (ev_q == 2'b10)) begin
      target_d[bus_if.ch_sel] = dec_duty;
    end
  end

  assign tick    = (presc_q == PS_TOP);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

`ifdef PWM_CENTER_ALIGNED_EN
  logic up_q, up_d;

  always_comb begin
    cnt_d    = cnt_q;
    up_d     = up_q;
    boundary = 1'b0;
    if (tick) begin
      if (up_q) begin
        boundary = (cnt_q == '0);
        if (cnt_q == CNT_TOP) begin
          cnt_d = cnt_q - 1'b1;
          up_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == RES_BITS'(1)) begin
        cnt_d = '0;
        up_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end
`else
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (tick) begin
      boundary = (cnt_q == CNT_TOP);
      cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    end
  end
`endif

  // The counter never reaches DMAX, so duty DMAX stays high for the whole period.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      level_q        <= '1;
      ev_q           <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
      presc_q        <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= INIT;
        active_q[i] <= INIT;
      end
      pwm_q          <= '0;
      duty_view_q    <= INIT;
      period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      up_q           <= 1'b1;
`endif
    end else begin
      sync1_q        <= raw;
      sync2_q        <= sync1_q;
      level_q        <= level_d;
      ev_q           <= ev_d;
      db_cnt_q       <= db_cnt_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      if (boundary) active_q <= target_q;
      pwm_q          <= pwm_d;
      duty_view_q    <= cur_duty;
      period_start_q <= boundary;
`ifdef PWM_CENTER_ALIGNED_EN
      up_q           <= up_d;
`endif
    end
  end

  assign bus_if.pwm_out      = pwm_q;
  assign bus_if.duty_view    = duty_view_q;
  assign bus_if.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (default sawtooth build) with a cycle-level reference model.
module tb_pwm_multi_channel;
  localparam int CH   = 4;
  localparam int RB   = 4;
  localparam int PS   = 1;
  localparam int DB   = 4;
  localparam int STEP = 3;
  localparam int INIT = 0;
  localparam int DMAX = 15;

  logic clk = 1'b0;
  logic rst;

  pwm_multi_channel_if #(.CHANNELS(CH), .RES_BITS(RB)) bus_if ();

  pwm_multi_channel #(
    .CHANNELS(CH), .RES_BITS(RB), .PRESCALE(PS),
    .DEBOUNCE_CYC(DB), .DUTY_STEP(STEP), .DUTY_INIT(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_if(bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;
  logic [RB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce as a window: the level flips once the last DB synchronised samples all disagree with it.
  bit            m_valid = 1'b0;
  int            m_n;
  logic [1:0]    raw_h[$];
  logic [1:0]    sync_h[$];
  logic [1:0]    m_lvl, m_pend;
  int            m_target[CH];
  int            m_active[CH];
  logic [CH-1:0] e_pwm;
  logic [RB-1:0] e_view;
  logic          e_ps;

  always @(posedge clk) begin
    logic [1:0] s, ev;
    int         cnt, sel;
    bit         bnd, flip;
    if (!rst) begin
      m_valid = 1'b1;
      m_n     = 0;
      raw_h.delete();
      sync_h.delete();
      m_lvl   = 2'b11;
      m_pend  = 2'b00;
      for (int i = 0; i < CH; i++) begin
        m_target[i] = INIT;
        m_active[i] = INIT;
      end
      e_pwm  = '0;
      e_view = RB'(INIT);
      e_ps   = 1'b0;
    end else if (m_valid) begin
      s = (raw_h.size() >= 2) ? raw_h[raw_h.size() - 2] : 2'b11;
      raw_h.push_back({bus_if.dec_n, bus_if.inc_n});
      if (raw_h.size() > 2) void'(raw_h.pop_front());
      sync_h.push_back(s);
      if (sync_h.size() > DB) void'(sync_h.pop_front());
      ev     = m_pend;
      m_pend = 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (sync_h.size() == DB) begin
          flip = 1'b1;
          foreach (sync_h[j]) if (sync_h[j][b] == m_lvl[b]) flip = 1'b0;
          if (flip) begin
            m_lvl[b] = ~m_lvl[b];
            if (m_lvl[b] == 1'b0) m_pend[b] = 1'b1;
          end
        end
      end
      sel = int'(bus_if.ch_sel);
      cnt = (m_n / PS) % DMAX;
      bnd = ((m_n % PS) == PS - 1) && (cnt == DMAX - 1);
      for (int i = 0; i < CH; i++) e_pwm[i] = (cnt < m_active[i]);
      e_view = RB'((sel < CH) ? m_target[sel] : 0);
      if (bnd) for (int i = 0; i < CH; i++) m_active[i] = m_target[i];
      e_ps = bnd;
      if (ev == 2'b01 && sel < CH)
        m_target[sel] = (m_target[sel] + STEP > DMAX) ? DMAX : m_target[sel] + STEP;
      else if (ev == 2'b10 && sel < CH)
        m_target[sel] = (m_target[sel] < STEP) ? 0 : m_target[sel] - STEP;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid && chk_en) begin
      check("model_pwm_out", 32'(bus_if.pwm_out), 32'(e_pwm));
      check("model_duty_view", 32'(bus_if.duty_view), 32'(e_view));
      check("model_period_start", 32'(bus_if.period_start), 32'(e_ps));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit do_inc, input bit do_dec, input int lo, input int hi);
    if (do_inc) bus_if.inc_n = 1'b0;
    if (do_dec) bus_if.dec_n = 1'b0;
    tick_n(lo);
    bus_if.inc_n = 1'b1;
    bus_if.dec_n = 1'b1;
    tick_n(hi);
  endtask

  task automatic wait_pstart();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus_if.period_start === 1'b1) ok = 1'b1;
    end
    check("period_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus_if.pwm_out[ch] === 1'b1) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, c1, c2, gap, kind;
    rst          = 1'b0;
    bus_if.inc_n = 1'b1;
    bus_if.dec_n = 1'b1;
    bus_if.ch_sel = '0;

    // reset state
    tick_n(3);
    check("rst_pwm_out", 32'(bus_if.pwm_out), 32'd0);
    check("rst_duty_view", 32'(bus_if.duty_view), 32'd0);
    check("rst_period_start", 32'(bus_if.period_start), 32'd0);
    rst = 1'b1;

    wait_pstart();
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus_if.period_start !== 1'b1 && gap < 40);
    check("period_length", 32'(gap), 32'd15);

    // increment with saturation on channel 1
    bus_if.ch_sel = 2'd1;
    exp_q = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
    repeat (6) begin
      press(1'b1, 1'b0, 10, 10);
      check("inc_duty_view", 32'(bus_if.duty_view), 32'(exp_q.pop_front()));
    end
    tick_n(30);
    count_high(1, 15, c);  check("ch1_full_high", 32'(c), 32'd15);
    count_high(0, 15, c);  check("ch0_idle_low", 32'(c), 32'd0);
    count_high(2, 15, c);  check("ch2_idle_low", 32'(c), 32'd0);
    count_high(3, 15, c);  check("ch3_idle_low", 32'(c), 32'd0);

    // bounce rejection on channel 2
    bus_if.ch_sel = 2'd2;
    tick_n(2);
    repeat (3) begin
      bus_if.inc_n = 1'b0; tick_n(2);
      bus_if.inc_n = 1'b1; tick_n(2);
    end
    press(1'b1, 1'b0, 10, 10);
    check("bounce_one_step", 32'(bus_if.duty_view), 32'd3);

    // decrement with saturation on channel 1
    bus_if.ch_sel = 2'd1;
    tick_n(2);
    check("dec_start_duty", 32'(bus_if.duty_view), 32'd15);
    exp_q = '{4'd12, 4'd9, 4'd6, 4'd3, 4'd0, 4'd0};
    repeat (6) begin
      press(1'b0, 1'b1, 10, 10);
      check("dec_duty_view", 32'(bus_if.duty_view), 32'(exp_q.pop_front()));
    end
    tick_n(30);
    count_high(1, 15, c);  check("ch1_full_low", 32'(c), 32'd0);

    // mid-period update on channel 0: event lands at counter 3
    bus_if.ch_sel = 2'd0;
    press(1'b1, 1'b0, 10, 10);
    press(1'b1, 1'b0, 10, 10);
    check("ch0_duty6", 32'(bus_if.duty_view), 32'd6);
    tick_n(20);
    wait_pstart();
    tick_n(12);
    fork
      press(1'b1, 1'b0, 10, 10);
      begin
        wait_pstart();
        count_high(0, 15, c1);
        count_high(0, 15, c2);
      end
    join
    check("midperiod_current_high", 32'(c1), 32'd6);
    check("midperiod_next_high", 32'(c2), 32'd9);

    // simultaneous presses, then reset mid-period
    tick_n(10);
    press(1'b1, 1'b1, 10, 10);
    check("simultaneous_no_change", 32'(bus_if.duty_view), 32'd9);
    tick_n(5);
    rst = 1'b0;
    tick_n(1);
    rst = 1'b1;
    check("midrst_pwm_out", 32'(bus_if.pwm_out), 32'd0);
    check("midrst_duty_view", 32'(bus_if.duty_view), 32'd0);
    check("midrst_period_start", 32'(bus_if.period_start), 32'd0);
    tick_n(3);
    check("post_rst_duty_view", 32'(bus_if.duty_view), 32'd0);
    count_high(0, 15, c);  check("post_rst_ch0_low", 32'(c), 32'd0);

    // randomized presses, bounces, channel changes and resets against the model
    repeat (80) begin
      bus_if.ch_sel = 2'($urandom_range(0, CH - 1));
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        tick_n(1);
        rst = 1'b1;
      end
      press(kind <= 4 || kind == 9, kind >= 5, $urandom_range(1, 12), $urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) bus_if.ch_sel = 2'($urandom_range(0, CH - 1));
      tick_n($urandom_range(0, 5));
    end
    tick_n(20);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
